// File: rtl/amo_sequencer.sv
// RV32A atomic sequencer: LR.W, SC.W and AMO read-modify-write over the data-memory port.
// Owns the single LR/SC reservation and stalls the core while a memory sequence is in flight.
module amo_sequencer #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [4:0]        funct5,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] rs2_data,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   input  logic              ext_wr_valid,
   input  logic [ADDR_W-1:0] ext_wr_addr,
   output logic              rd_we,
   output logic [DATA_W-1:0] rd_data,
   output logic              reserved_flag,
   output logic              misalign
);

   localparam int unsigned WORD_W = ADDR_W - 2;

   localparam logic [4:0] F_ADD  = 5'b00000;
   localparam logic [4:0] F_LR   = 5'b00010;
   localparam logic [4:0] F_SC   = 5'b00011;
   localparam logic [4:0] F_XOR  = 5'b00100;
   localparam logic [4:0] F_OR   = 5'b01000;
   localparam logic [4:0] F_AND  = 5'b01100;
   localparam logic [4:0] F_MIN  = 5'b10000;
   localparam logic [4:0] F_MAX  = 5'b10100;
   localparam logic [4:0] F_MINU = 5'b11000;
   localparam logic [4:0] F_MAXU = 5'b11100;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [4:0]          funct5_q, funct5_d;
   logic [DATA_W-1:0]   rs2_q, rs2_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic                rd_we_q, rd_we_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                misalign_q, misalign_d;
   logic                res_valid_q, res_valid_d;
   logic [WORD_W-1:0]   res_addr_q, res_addr_d;

   logic [WORD_W-1:0]   addr_word;
   logic [WORD_W-1:0]   cur_word;
   logic                unused_ext_lo;

   assign addr_word     = addr[ADDR_W-1:2];
   assign cur_word      = mem_addr_q[ADDR_W-1:2];
   assign unused_ext_lo = ^ext_wr_addr[1:0];

   // Read-modify-write result; anything not listed behaves as SWAP.
   function automatic logic [DATA_W-1:0] amo_calc(input logic [4:0]        op,
                                                  input logic [DATA_W-1:0] old,
                                                  input logic [DATA_W-1:0] src);
      logic [DATA_W-1:0] res;
      res = src;
      case (op)
         F_ADD:   res = old + src;
         F_XOR:   res = old ^ src;
         F_AND:   res = old & src;
         F_OR:    res = old | src;
         F_MIN:   res = ($signed(old) < $signed(src)) ? old : src;
         F_MAX:   res = ($signed(old) > $signed(src)) ? old : src;
         F_MINU:  res = (old < src) ? old : src;
         F_MAXU:  res = (old > src) ? old : src;
         default: res = src;
      endcase
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         funct5_q    <= 5'b0;
         rs2_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         rd_we_q     <= 1'b0;
         rd_data_q   <= '0;
         misalign_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         funct5_q    <= funct5_d;
         rs2_q       <= rs2_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         rd_we_q     <= rd_we_d;
         rd_data_q   <= rd_data_d;
         misalign_q  <= misalign_d;
         res_valid_q <= res_valid_d;
         res_addr_q  <= res_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      funct5_d    = funct5_q;
      rs2_d       = rs2_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rd_data_d   = rd_data_q;
      misalign_d  = 1'b0;
      res_valid_d = res_valid_q;
      res_addr_d  = res_addr_q;

      // External write clear comes first so a same-cycle LR set overrides it.
      if (ext_wr_valid && (ext_wr_addr[ADDR_W-1:2] == res_addr_q)) begin
         res_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               funct5_d   = funct5;
               rs2_d      = rs2_data;
               mem_addr_d = {addr_word, 2'b00};
               if (addr[1:0] != 2'b00) begin
                  misalign_d = 1'b1;
               end else if (funct5 == F_SC) begin
                  res_valid_d = 1'b0;
                  if (res_valid_q && (res_addr_q == addr_word)) begin
                     mem_wdata_d = rs2_data;
                     state_d     = S_WR;
                  end else begin
                     rd_data_d = DATA_W'(1);
                     state_d   = S_DONE;
                  end
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            if (mem_ready) begin
               rd_data_d = mem_rdata;
               if (funct5_q == F_LR) begin
                  res_valid_d = 1'b1;
                  res_addr_d  = cur_word;
                  state_d     = S_DONE;
               end else begin
                  mem_wdata_d = amo_calc(funct5_q, mem_rdata, rs2_q);
                  state_d     = S_WR;
               end
            end
         end
         S_WR: begin
            if (mem_ready) begin
               if (funct5_q == F_SC) begin
                  rd_data_d = '0;
               end else if (cur_word == res_addr_q) begin
                  res_valid_d = 1'b0;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      mem_req_d = (state_d == S_RD) || (state_d == S_WR);
      mem_we_d  = (state_d == S_WR);
      rd_we_d   = (state_d == S_DONE);
   end

   assign stall         = mem_req_q | ((state_q == S_IDLE) & start);
   assign mem_req       = mem_req_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign rd_we         = rd_we_q;
   assign rd_data       = rd_data_q;
   assign reserved_flag = res_valid_q;
   assign misalign      = misalign_q;

endmodule
